// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 10;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Layout of one queued fetch at the default widths: address above instruction.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} words with clear, full/empty flags and
// pointer wrap that also works for non-power-of-two depths.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FETCH_ADDR_W + FETCH_INSTR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding memory read per PC value, queued for decode,
// with branch flush that drops queued and in-flight fetches.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = FETCH_ADDR_W,
    parameter int INSTR_WIDTH = FETCH_INSTR_W,
    parameter int DEPTH       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   flush,
    output logic                   fetch_stall,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_rvalid,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    input  logic                   out_ready
);

    fetch_state_t                        state;
    logic                                push;
    logic                                pop;
    logic                                full;
    logic                                empty;
    logic [ADDR_WIDTH+INSTR_WIDTH-1:0]   head;

    assign push      = (state == WAIT) && mem_rvalid && !flush;
    assign pop       = out_valid && out_ready;
    // The PC moves on a branch or on the cycle an instruction is captured.
    assign fetch_stall = !(flush || ((state == WAIT) && mem_rvalid));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!full && !flush) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH + INSTR_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data ({mem_addr, mem_rdata}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Outputs read as zero whenever nothing is queued.
    assign out_valid = !empty;
    assign out_pc    = empty ? '0 : head[INSTR_WIDTH +: ADDR_WIDTH];
    assign out_instr = empty ? '0 : head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a PC model, a variable-latency memory and an
// in-order stream expectation for what decode should receive.
module tb_instruction_fetch;

    localparam int AW    = 10;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc = '0;
    logic          flush = 1'b0;
    logic          fetch_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready = 1'b0;

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .pc(pc), .flush(flush),
        .fetch_stall(fetch_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW-1:0] pc_m, exp_pc, req_addr, flush_target;
    int  age, cur_lat, lat_fixed, pops, reqs, stall_lows;
    bit  lat_rand, stale, flush_now, rdy;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a) + 32'h100;
    endfunction

    task automatic init_bench(input logic [AW-1:0] start);
        pc_m = start; exp_pc = start; pc = start;
        age = 0; stale = 0; flush_now = 0; cur_lat = 0;
        pops = 0; reqs = 0; stall_lows = 0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the PC model.
    task automatic step();
        logic          rv, exp_stall, stall_s, fl_s, req_s;
        logic [AW-1:0] tgt, diff;
        if (mem_req && age == 0) begin
            cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            req_addr = mem_addr;
            reqs++;
        end
        rv         = mem_req && (age >= cur_lat);
        mem_rvalid = rv;
        mem_rdata  = rv ? mem_word(mem_addr) : $urandom;
        out_ready  = rdy;
        flush      = flush_now;
        #1;
        if (mem_req && age > 0) begin
            n_assert++;
            if (mem_addr !== req_addr) begin
                n_fail++;
                $display("FAIL addr_stable: mem_addr %h expected %h", mem_addr, req_addr);
            end
        end
        exp_stall = !(flush_now || (rv && !stale));
        n_assert++;
        if (fetch_stall !== exp_stall) begin
            n_fail++;
            $display("FAIL fetch_stall: got %b expected %b (flush %b rvalid %b)", fetch_stall, exp_stall, flush_now, rv);
        end
        diff = pc_m - exp_pc;
        n_assert++;
        if (out_valid ? (diff < 1 || diff > DEPTH) : (diff != 0)) begin
            n_fail++;
            $display("FAIL captured_count: out_valid %b with pc %h head-expected %h", out_valid, pc_m, exp_pc);
        end
        if (out_valid && out_ready && !flush_now) begin
            n_assert++;
            if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL stream: got pc %h instr %h expected pc %h instr %h", out_pc, out_instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc++;
            pops++;
        end
        if (!fetch_stall) stall_lows++;
        stall_s = fetch_stall;
        fl_s    = flush_now;
        tgt     = flush_target;
        req_s   = mem_req;
        if (flush_now && mem_req && !rv) stale = 1;
        @(posedge clock);
        if (rv) begin
            age = 0; stale = 0;
        end else if (req_s) begin
            age++;
        end
        @(negedge clock);
        if (fl_s) begin
            pc_m = tgt; exp_pc = tgt;
        end else if (!stall_s) begin
            pc_m++;
        end
        pc = pc_m;
        flush_now = 0;
        flush = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_assert++;
        if (out_valid !== 1'b0 || out_instr !== '0 || out_pc !== '0) begin
            n_fail++;
            $display("FAIL %s_out: valid %b instr %h pc %h expected all zero", tag, out_valid, out_instr, out_pc);
        end
        n_assert++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL %s_mem: req %b addr %h expected 0/0", tag, mem_req, mem_addr);
        end
        n_assert++;
        if (fetch_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_stall: got %b expected 1", tag, fetch_stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        init_bench('0);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        lat_rand = 0; lat_fixed = 0; rdy = 1;
        pops = 0; stall_lows = 0;
        repeat (40) step();
        n_assert++;
        if (stall_lows != 20) begin
            n_fail++;
            $display("FAIL zero_wait_stall_lows: got %0d expected 20", stall_lows);
        end
        n_assert++;
        if (pops != 19) begin
            n_fail++;
            $display("FAIL zero_wait_pops: got %0d expected 19", pops);
        end
    endtask

    task automatic test_latency();
        lat_fixed = 3; rdy = 1; pops = 0; reqs = 0;
        repeat (40) step();
        n_assert++;
        if (pops < 5 || pops > reqs) begin
            n_fail++;
            $display("FAIL latency_pushes: pops %0d requests %0d", pops, reqs);
        end
    endtask

    task automatic test_fill_drain();
        rdy = 0;
        repeat (20) step();
        n_assert++;
        if (out_valid !== 1'b1 || mem_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_state: valid %b req %b stall %b expected 1 0 1", out_valid, mem_req, fetch_stall);
        end
        n_assert++;
        if (AW'(pc_m - exp_pc) != AW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_depth: queued %0d expected %0d", pc_m - exp_pc, DEPTH);
        end
        rdy = 1; pops = 0;
        repeat (30) step();
        n_assert++;
        if (pops < DEPTH + 2) begin
            n_fail++;
            $display("FAIL drain_resume: pops %0d expected at least %0d", pops, DEPTH + 2);
        end
    endtask

    task automatic test_flush_pending();
        int i;
        lat_fixed = 4; rdy = 0;
        for (i = 0; i < 60 && !(out_valid && mem_req && age == 1); i++) step();
        n_assert++;
        if (!(out_valid && mem_req && age == 1)) begin
            n_fail++;
            $display("FAIL flush_pending_setup: timeout valid %b req %b age %0d", out_valid, mem_req, age);
        end
        flush_now = 1; flush_target = 10'h3A0;
        step();
        n_assert++;
        if (out_valid !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_discard: valid %b req %b expected 0 1", out_valid, mem_req);
        end
        rdy = 1; pops = 0;
        for (i = 0; i < 30 && !(mem_req && age == 0 && !stale); i++) step();
        n_assert++;
        if (mem_addr !== 10'h3A0 || !mem_req) begin
            n_fail++;
            $display("FAIL flush_new_addr: req %b addr %h expected 1 3a0", mem_req, mem_addr);
        end
        repeat (15) step();
        n_assert++;
        if (pops == 0) begin
            n_fail++;
            $display("FAIL flush_resume: pops %0d expected > 0", pops);
        end
    endtask

    task automatic test_flush_same_cycle();
        int i;
        lat_fixed = 0; rdy = 0;
        for (i = 0; i < 20 && !(out_valid && mem_req); i++) step();
        n_assert++;
        if (!(out_valid && mem_req)) begin
            n_fail++;
            $display("FAIL same_cycle_setup: timeout valid %b req %b", out_valid, mem_req);
        end
        flush_now = 1; flush_target = 10'h155; rdy = 1;
        step();
        n_assert++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_clear: valid %b req %b expected 0 0", out_valid, mem_req);
        end
        pops = 0;
        repeat (10) step();
        n_assert++;
        if (pops == 0) begin
            n_fail++;
            $display("FAIL same_cycle_resume: pops %0d expected > 0", pops);
        end
    endtask

    task automatic test_random();
        lat_rand = 1; pops = 0;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                flush_now = 1;
                flush_target = AW'($urandom);
            end
            step();
        end
        lat_rand = 0;
        n_assert++;
        if (pops < 20) begin
            n_fail++;
            $display("FAIL random_progress: pops %0d expected at least 20", pops);
        end
    endtask

    task automatic test_reset_in_wait();
        int i;
        lat_fixed = 5; rdy = 1;
        for (i = 0; i < 30 && !(mem_req && age == 2); i++) step();
        n_assert++;
        if (!(mem_req && age == 2)) begin
            n_fail++;
            $display("FAIL reset_wait_setup: timeout req %b age %0d", mem_req, age);
        end
        #2;
        reset = 1'b1;
        mem_rvalid = 1'b0;
        #1;
        check_reset_outputs("reset_in_wait");
        repeat (2) @(negedge clock);
        init_bench(10'h050);
        reset = 1'b0;
        repeat (3) step();
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_push: out_valid %b expected 0", out_valid);
        end
        repeat (20) step();
        n_assert++;
        if (pops == 0) begin
            n_fail++;
            $display("FAIL reset_resume: pops %0d expected > 0", pops);
        end
    endtask

    initial begin
        lat_rand = 0; lat_fixed = 0; rdy = 0;
        flush_target = '0; req_addr = '0;
        init_bench('0);
        @(negedge clock);
        test_reset();
        test_zero_wait();
        test_latency();
        test_fill_drain();
        test_flush_pending();
        test_flush_same_cycle();
        test_random();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and decode. Reads the instruction at the current `pc` from instruction memory over a single-outstanding request/response handshake and queues `{pc, instruction}` pairs in a small FIFO for decode. Drives the PC's `halt` input so the PC advances only when the instruction at `pc` has been captured. Discards queued and in-flight fetches on a taken branch.

## Interface
- `ADDR_WIDTH`, 10: PC and memory address width.
- `INSTR_WIDTH`, 32: instruction width.
- `DEPTH`, 2: FIFO entries, at least 2.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  ADDR_WIDTH  current `programCounter` from the PC.
- `flush`  in  1  taken branch; same net as the PC's `branchSignal`.
- `fetch_stall`  out  1  drives the PC `halt` input.
- `mem_req`  out  1  read request, registered.
- `mem_addr`  out  ADDR_WIDTH  read address, registered, stable while `mem_req`=1.
- `mem_rvalid`  in  1  read data valid; completes the outstanding request.
- `mem_rdata`  in  INSTR_WIDTH  read data.
- `out_valid`  out  1  FIFO head valid.
- `out_instr`  out  INSTR_WIDTH  FIFO head instruction.
- `out_pc`  out  ADDR_WIDTH  FIFO head address.
- `out_ready`  in  1  decode accepts the head.

## Operation
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - If FIFO not full and `flush`=0: at the edge, set `mem_req`=1 and `mem_addr`=`pc`, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT (`mem_req`=1):
  - `mem_rvalid`=1, `flush`=0: push `{mem_addr, mem_rdata}`, drop `mem_req`, go to IDLE.
  - `mem_rvalid`=1, `flush`=1: drop the response, go to IDLE.
  - `mem_rvalid`=0, `flush`=1: go to DISCARD.
  - `mem_rvalid`=0, `flush`=0: stay in WAIT.
- DISCARD (`mem_req`=1):
  - Wait for `mem_rvalid`, drop the data, go to IDLE.
  - A further `flush` keeps the state in DISCARD.
- `fetch_stall` is combinational. It is 0 when `flush`=1, or when the state is WAIT with `mem_rvalid`=1. Otherwise it is 1. This ensures the PC increments exactly once per captured instruction and always takes a branch.
- FIFO:
  - Pop on `out_valid` && `out_ready`.
  - Push only from WAIT. A request is issued only when the FIFO is not full, so a push never overflows.
  - Simultaneous push and pop in the same cycle is legal when the FIFO is full; no overflow can occur.
- `flush` empties the FIFO at the edge. It overrides a same-cycle pop and push.
- Memory contract: one request outstanding at a time. `mem_rvalid` may assert in any cycle while `mem_req`=1, including the first cycle, and never when `mem_req`=0.

## Timing
- Reset state: IDLE, FIFO empty, `out_valid`=0, `out_instr`=0, `out_pc`=0, `mem_req`=0, `mem_addr`=0, `fetch_stall`=1.
- With a zero-wait memory:
  - IDLE at cycle N, `mem_req` high at N+1, `mem_rvalid` at N+1.
  - `out_valid` high at N+2. The PC has advanced at the N+1→N+2 edge.
- Throughput is one instruction per 2 cycles.
- Reset asserted mid-operation returns to the reset state immediately. Any in-flight response is ignored because `mem_req`=0.
- `out_*` are driven from FIFO registers only. There is no combinational path from `mem_rdata` to `out_*`.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum (IDLE/WAIT/DISCARD).
  - Default width constants `FETCH_ADDR_W`=10 and `FETCH_INSTR_W`=32.
  - Entry struct `{pc, instr}`.
- Sub-module `fetch_fifo`: parameterised DEPTH × (ADDR_WIDTH+INSTR_WIDTH) synchronous FIFO with a clear input, full/empty flags and pointer wrap. The FSM and handshake logic stay in `instruction_fetch`.

## Test plan
- Reset, then zero-wait memory with `mem_rdata`=`mem_addr`+0x100, `out_ready`=1, `pc` starting at 0 → `out_pc` sequence 0,1,2,… with `out_instr` 0x100,0x101,…. `fetch_stall` is low once per 2 cycles.
- Memory latency of 3 cycles → `mem_addr` held stable for 3 cycles and `fetch_stall`=1 throughout. Exactly one push per request.
- `out_ready`=0 → FIFO fills to DEPTH. `mem_req` stays 0 and `fetch_stall`=1. Raising `out_ready` drains in order and fetching resumes.
- `flush` in WAIT with response still pending → state goes to DISCARD, the late response is dropped, and the FIFO is empty. The next request uses the new `pc` (e.g. 0x3A0) and no stale instruction appears on `out_*`.
- `flush` in the same cycle as `mem_rvalid` and a pop → response dropped, FIFO cleared, `fetch_stall`=0 that cycle.
- Assert `reset` while in WAIT → all outputs return to reset values the same cycle; no push occurs after `reset` is released.
